// File: rtl/mult_share_pkg.sv
// Shared constants, helper function and pipeline entry type for the shared
// 8x8 multiplier arbiter.
package mult_share_pkg;

    localparam int MUL_W    = 8;
    localparam int PROD_W   = 16;
    localparam int ID_MAX_W = 3;   // wide enough for up to 8 requesters

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    typedef struct packed {
        logic [MUL_W-1:0]    a;
        logic [MUL_W-1:0]    b;
        logic [ID_MAX_W-1:0] id;
    } entry_t;

endpackage

// File: rtl/array_mult8.sv
// Combinational 8x8 unsigned array multiplier: sum of shifted partial products.
module array_mult8
    import mult_share_pkg::*;
(
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < MUL_W; i++) begin
            if (b[i]) p = p + (PROD_W'(a) << i);
        end
    end

endmodule

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, wrapping;
// ptr advances past the winner only when the grant is actually taken.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] gidx
);

    logic [ID_W-1:0] ptr;
    logic            found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr <= '0;
        else if (accept) ptr <= ID_W'((int'(gidx) + 1) % NREQ);
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 8x8 multiplier between NREQ requesters through a two-stage
// (operand, product) pipeline with round-robin arbitration and id tagging.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int CNT_W = 16,
    localparam int ID_W  = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*MUL_W-1:0] req_a,
    input  logic [NREQ*MUL_W-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PROD_W-1:0]     res_p,
    output logic [ID_W-1:0]       res_id,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);

    logic              s1_v, s2_v, s1_free, s2_free, accept;
    entry_t            s1, s1_nxt;
    logic [PROD_W-1:0] prod, s2_p;
    logic [ID_W-1:0]   s2_id, gidx;
    logic [NREQ-1:0]   grant;
    logic              id_hi_unused;

    assign s2_free   = !s2_v || res_ready;
    assign s1_free   = !s1_v || s2_free;
    assign req_ready = grant & {NREQ{s1_free}};
    assign accept    = |req_ready;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .gidx   (gidx)
    );

    always_comb begin
        s1_nxt.a  = req_a[MUL_W*int'(gidx) +: MUL_W];
        s1_nxt.b  = req_b[MUL_W*int'(gidx) +: MUL_W];
        s1_nxt.id = ID_MAX_W'(gidx);
    end

    array_mult8 u_mul (
        .a (s1.a),
        .b (s1.b),
        .p (prod)
    );

    // Both stages move in the same cycle when downstream frees up, so a
    // drain and a fresh accept never leave a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1       <= '0;
            s2_v     <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
            ops_done <= '0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
                s1   <= s1_nxt;
            end else if (s2_free) begin
                s1_v <= 1'b0;
            end
            if (s1_v && s2_free) begin
                s2_v  <= 1'b1;
                s2_p  <= prod;
                s2_id <= s1.id[ID_W-1:0];
            end else if (res_ready) begin
                s2_v <= 1'b0;
            end
            if (s2_v && res_ready) ops_done <= ops_done + CNT_W'(1);
        end
    end

    // Upper id bits are structurally zero for small NREQ.
    assign id_hi_unused = ^s1.id;

    assign res_valid = s2_v;
    assign res_p     = s2_p;
    assign res_id    = s2_id;
    assign busy      = s1_v || s2_v;

endmodule
